// File: rtl/perceptron_train_unit_pkg.sv
// Shared types and helpers for the perceptron weight-table engine.
package perceptron_train_unit_pkg;

  // Table engine operating mode: clearing the table, or serving traffic.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Width of a signed dot product of HIST_LEN+1 weights, wide enough to never overflow.
  function automatic int sum_width(input int weight_w, input int hist_len);
    return weight_w + $clog2(hist_len + 2);
  endfunction

  // Saturating +1 on a two's-complement value of the given width.
  function automatic int sat_inc(input int value, input int width);
    int max_v;
    max_v = (1 << (width - 1)) - 1;
    return (value >= max_v) ? max_v : value + 1;
  endfunction

  // Saturating -1 on a two's-complement value of the given width.
  function automatic int sat_dec(input int value, input int width);
    int min_v;
    min_v = -(1 << (width - 1));
    return (value <= min_v) ? min_v : value - 1;
  endfunction

endpackage

// File: rtl/perceptron_train_unit_row_update.sv
// Combinational training step for one weight row: every weight moves one step
// toward agreement with the resolved direction, saturating at the weight limits.
module perceptron_row_update
  import perceptron_train_unit_pkg::*;
#(
  parameter int HIST_LEN = 16,
  parameter int WEIGHT_W = 8,
  parameter int BIAS_EN  = 1
) (
  input  logic [(HIST_LEN+1)*WEIGHT_W-1:0] i_row,
  input  logic [HIST_LEN-1:0]              i_ghist,
  input  logic                             i_taken,
  output logic [(HIST_LEN+1)*WEIGHT_W-1:0] o_row
);

  // One saturating step of a single weight, up or down.
  function automatic logic [WEIGHT_W-1:0] step_weight(input logic [WEIGHT_W-1:0] w,
                                                      input logic up);
    int v;
    v = int'($signed(w));
    return up ? WEIGHT_W'(sat_inc(v, WEIGHT_W)) : WEIGHT_W'(sat_dec(v, WEIGHT_W));
  endfunction

  // Build the trained row: bias follows the outcome, history weights follow agreement.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    o_row = '0;
    if (BIAS_EN != 0) begin
      o_row[WEIGHT_W-1:0] = step_weight(i_row[WEIGHT_W-1:0], i_taken);
    end
    for (int i = 1; i <= HIST_LEN; i++) begin
      o_row[i*WEIGHT_W +: WEIGHT_W] = step_weight(i_row[i*WEIGHT_W +: WEIGHT_W],
                                                  i_ghist[i-1] == i_taken);
    end
  end

endmodule

// File: rtl/perceptron_train_unit.sv
// Perceptron weight table with a 1-cycle lookup port and a 2-stage
// read-modify-write training pipeline; clears the table after every reset.
module perceptron_train_unit
  import perceptron_train_unit_pkg::*;
#(
  parameter  int NUM_ROWS = 64,
  parameter  int HIST_LEN = 16,
  parameter  int WEIGHT_W = 8,
  parameter  int THETA    = 37,
  parameter  int BIAS_EN  = 1,
  localparam int IDX_W    = $clog2(NUM_ROWS),
  localparam int SUM_W    = sum_width(WEIGHT_W, HIST_LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lkp_valid,
  input  logic [IDX_W-1:0]        lkp_idx,
  input  logic [HIST_LEN-1:0]     lkp_ghist,
  output logic                    lkp_out_valid,
  output logic signed [SUM_W-1:0] lkp_sum,
  output logic                    lkp_taken,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [IDX_W-1:0]        upd_idx,
  input  logic [HIST_LEN-1:0]     upd_ghist,
  input  logic                    upd_taken,
  input  logic                    upd_pred_taken,
  input  logic signed [SUM_W-1:0] upd_sum,
  output logic                    upd_trained,
  output logic                    init_done
);

  localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;

  // Control state
  state_e              r_state;
  logic [IDX_W-1:0]    r_init_cnt;
  logic                r_init_done;
  logic                r_upd_ready;

  // Weight table, one packed row per entry (weight 0 = bias in the low bits)
  logic [ROW_W-1:0]    r_table [NUM_ROWS];

  // Lookup path
  logic [ROW_W-1:0]    w_lkp_row;
  logic signed [SUM_W-1:0] w_lkp_sum;
  logic signed [SUM_W-1:0] w_term;
  logic                r_lkp_out_valid;
  logic signed [SUM_W-1:0] r_lkp_sum;
  logic                r_lkp_taken;

  // Training path
  logic                w_accept;
  logic signed [SUM_W:0] w_sum_ext;
  logic [SUM_W:0]      w_abs_sum;
  logic                w_train;
  logic [ROW_W-1:0]    w_s0_row;
  logic [ROW_W-1:0]    w_s1_new_row;
  logic                r_s1_train;
  logic [IDX_W-1:0]    r_s1_idx;
  logic [HIST_LEN-1:0] r_s1_ghist;
  logic                r_s1_taken;
  logic [ROW_W-1:0]    r_s1_row;

  // Table write port
  logic                w_we;
  logic [IDX_W-1:0]    w_waddr;
  logic [ROW_W-1:0]    w_wdata;

  // INIT/RUN FSM: sweep a zero row through the table, then open both ports.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_upd_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == IDX_W'(NUM_ROWS - 1)) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
            r_upd_ready <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + IDX_W'(1);
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Single write port: the clear sweep owns it during INIT, training S1 afterwards.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_s1_idx;
    w_wdata = w_s1_new_row;
    if (r_state == ST_INIT) begin
      w_we    = 1'b1;
      w_waddr = r_init_cnt;
      w_wdata = '0;
    end else if (r_s1_train) begin
      w_we = 1'b1;
    end
  end

  // Weight table storage.
  always_ff @(posedge clk) begin
    // NOTE: the table is deliberately not reset so it maps onto RAM; the INIT sweep clears it instead.
    if (w_we) begin
      r_table[w_waddr] <= w_wdata;
    end
  end

  // Lookup dot product: bias plus +/- each history weight, sign-extended to SUM_W.
  assign w_lkp_row = r_table[lkp_idx];

  always_comb begin
    w_lkp_sum = '0;
    w_term    = '0;
    if (BIAS_EN != 0) begin
      w_lkp_sum = SUM_W'($signed(w_lkp_row[WEIGHT_W-1:0]));
    end
    for (int i = 0; i < HIST_LEN; i++) begin
      w_term    = SUM_W'($signed(w_lkp_row[(i+1)*WEIGHT_W +: WEIGHT_W]));
      w_lkp_sum = lkp_ghist[i] ? (w_lkp_sum + w_term) : (w_lkp_sum - w_term);
    end
  end

  // Lookup result register; requests during INIT are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lkp_out_valid <= 1'b0;
      r_lkp_sum       <= '0;
      r_lkp_taken     <= 1'b0;
    end else begin
      r_lkp_out_valid <= lkp_valid && (r_state == ST_RUN);
      if (lkp_valid && (r_state == ST_RUN)) begin
        r_lkp_sum   <= w_lkp_sum;
        r_lkp_taken <= ~w_lkp_sum[SUM_W-1];
      end
    end
  end

  // S0: decide whether this outcome trains; |sum| is one bit wider so the most-negative sum stays positive.
  assign w_accept  = upd_valid && r_upd_ready;
  assign w_sum_ext = {upd_sum[SUM_W-1], upd_sum};
  assign w_abs_sum = w_sum_ext[SUM_W] ? -w_sum_ext : w_sum_ext;
  assign w_train   = (upd_taken != upd_pred_taken) || (w_abs_sum <= (SUM_W+1)'(THETA));

  // S0 row read, forwarding the row S1 writes this same cycle so back-to-back updates accumulate.
  assign w_s0_row = (r_s1_train && (r_s1_idx == upd_idx)) ? w_s1_new_row : r_table[upd_idx];

  // S0 -> S1 pipeline register; only accepted requests that train reach the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_train <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_ghist <= '0;
      r_s1_taken <= 1'b0;
      r_s1_row   <= '0;
    end else begin
      r_s1_train <= w_accept && w_train;
      if (w_accept) begin
        r_s1_idx   <= upd_idx;
        r_s1_ghist <= upd_ghist;
        r_s1_taken <= upd_taken;
        r_s1_row   <= w_s0_row;
      end
    end
  end

  // S1: compute the trained row; it is written at the end of this cycle.
  perceptron_row_update #(
    .HIST_LEN (HIST_LEN),
    .WEIGHT_W (WEIGHT_W),
    .BIAS_EN  (BIAS_EN)
  ) u_row_update (
    .i_row   (r_s1_row),
    .i_ghist (r_s1_ghist),
    .i_taken (r_s1_taken),
    .o_row   (w_s1_new_row)
  );

  assign lkp_out_valid = r_lkp_out_valid;
  assign lkp_sum       = r_lkp_sum;
  assign lkp_taken     = r_lkp_taken;
  assign upd_ready     = r_upd_ready;
  assign upd_trained   = r_s1_train;
  assign init_done     = r_init_done;

endmodule
